// File: rtl/mult_accum_wb.sv
// mult_accum_wb: accumulates a programmed number of signed products and writes the sum
// back through the register-file write port. Define SATURATE_EN for clamping plus a sticky ovf flag.
module mult_accum_wb #(
    parameter int P_W    = 16,
    parameter int REG_W  = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic [ADDR_W-1:0] dest,
    output logic              busy,
    input  logic              p_valid,
    output logic              p_ready,
    input  logic [P_W-1:0]    p_data,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [ADDR_W-1:0] w_addr,
    output logic [REG_W-1:0]  w_data,
    output logic              done,
    output logic              ovf
);
    typedef enum logic [1:0] {IDLE, ACC, WRITE} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  len_q, len_nx, cnt, cnt_nx, cnt_inc;
    logic [REG_W-1:0]  acc, acc_nx, acc_add;
    logic              add_ovf;
    logic              busy_nx, p_ready_nx, w_valid_nx, done_nx, ovf_nx;
    logic [ADDR_W-1:0] w_addr_nx;
    logic [REG_W-1:0]  w_data_nx;

`ifdef SATURATE_EN
    localparam logic [REG_W-1:0] MAX_POS = {1'b0, {(REG_W-1){1'b1}}};
    localparam logic [REG_W-1:0] MAX_NEG = {1'b1, {(REG_W-1){1'b0}}};
    logic [REG_W:0] sum_wide;

    // One guard bit: overflow when the two top bits of the widened sum disagree.
    always_comb begin
        sum_wide = (REG_W+1)'($signed(acc)) + (REG_W+1)'($signed(p_data));
        acc_add  = sum_wide[REG_W-1:0];
        add_ovf  = 1'b0;
        if (sum_wide[REG_W] != sum_wide[REG_W-1]) begin
            acc_add = sum_wide[REG_W] ? MAX_NEG : MAX_POS;
            add_ovf = 1'b1;
        end
    end
`else
    always_comb begin
        acc_add = acc + REG_W'($signed(p_data));
        add_ovf = 1'b0;
    end
`endif

    assign cnt_inc = cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            len_q   <= '0;
            cnt     <= '0;
            acc     <= '0;
            busy    <= 1'b0;
            p_ready <= 1'b0;
            w_valid <= 1'b0;
            w_addr  <= '0;
            w_data  <= '0;
            done    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            state   <= state_nx;
            len_q   <= len_nx;
            cnt     <= cnt_nx;
            acc     <= acc_nx;
            busy    <= busy_nx;
            p_ready <= p_ready_nx;
            w_valid <= w_valid_nx;
            w_addr  <= w_addr_nx;
            w_data  <= w_data_nx;
            done    <= done_nx;
            ovf     <= ovf_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        len_nx     = len_q;
        cnt_nx     = cnt;
        acc_nx     = acc;
        busy_nx    = busy;
        p_ready_nx = p_ready;
        w_valid_nx = w_valid;
        w_addr_nx  = w_addr;
        w_data_nx  = w_data;
        done_nx    = 1'b0;
        ovf_nx     = ovf;
        case (state)
            IDLE: begin
                if (start) begin
                    len_nx    = len;
                    w_addr_nx = dest;
                    acc_nx    = '0;
                    cnt_nx    = '0;
                    ovf_nx    = 1'b0;
                    busy_nx   = 1'b1;
                    if (len == '0) begin
                        state_nx   = WRITE;
                        w_valid_nx = 1'b1;
                        w_data_nx  = '0;
                    end else begin
                        state_nx   = ACC;
                        p_ready_nx = 1'b1;
                    end
                end
            end
            ACC: begin
                if (p_valid && p_ready) begin
                    acc_nx = acc_add;
                    cnt_nx = cnt_inc;
                    ovf_nx = ovf | add_ovf;
                    if (cnt_inc == len_q) begin
                        state_nx   = WRITE;
                        p_ready_nx = 1'b0;
                        w_valid_nx = 1'b1;
                        w_data_nx  = acc_add;
                    end
                end
            end
            WRITE: begin
                if (w_valid && w_ready) begin
                    state_nx   = IDLE;
                    w_valid_nx = 1'b0;
                    done_nx    = 1'b1;
                    busy_nx    = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mult_accum_wb.sv
// tb_mult_accum_wb: directed and randomized bursts checked against an arithmetic model
// of the multiply-accumulate write-back stage (follows SATURATE_EN when defined).
module tb_mult_accum_wb;
    localparam int P_W    = 16;
    // Narrow accumulator so bursts within the 255-product limit can cross the signed range.
    localparam int REG_W  = 22;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  len = '0;
    logic [ADDR_W-1:0] dest = '0;
    logic              busy;
    logic              p_valid = 1'b0;
    logic              p_ready;
    logic [P_W-1:0]    p_data = '0;
    logic              w_valid;
    logic              w_ready = 1'b0;
    logic [ADDR_W-1:0] w_addr;
    logic [REG_W-1:0]  w_data;
    logic              done;
    logic              ovf;

    int n_cmp = 0;
    int n_err = 0;
    int prods[$];

    mult_accum_wb #(.P_W(P_W), .REG_W(REG_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .dest(dest), .busy(busy),
        .p_valid(p_valid), .p_ready(p_ready), .p_data(p_data), .w_valid(w_valid),
        .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sum of the product list under the configured overflow rule.
    task automatic model(output logic [REG_W-1:0] sum, output logic o);
        longint a = 0;
        logic signed [REG_W-1:0] t;
        o = 1'b0;
        foreach (prods[i]) begin
            a = a + longint'(prods[i]);
`ifdef SATURATE_EN
            if (a > (longint'(1) <<< (REG_W-1)) - 1) begin
                a = (longint'(1) <<< (REG_W-1)) - 1;
                o = 1'b1;
            end else if (a < -(longint'(1) <<< (REG_W-1))) begin
                a = -(longint'(1) <<< (REG_W-1));
                o = 1'b1;
            end
`else
            t = a[REG_W-1:0];
            a = longint'(t);
`endif
        end
        sum = a[REG_W-1:0];
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            check("idle_done", done, 0);
            check("idle_wvalid", w_valid, 0);
        end
    endtask

    // Runs one burst from the current negedge; returns on the negedge where done is high.
    task automatic run_burst(input int n, input int d, input int gap_pct, input int stall);
        logic [REG_W-1:0] exp_sum;
        logic exp_ovf;
        int idx = 0;
        int cyc = 0;
        bit v;
        model(exp_sum, exp_ovf);
        check("idle_busy", busy, 0);
        start = 1'b1; len = CNT_W'(n); dest = ADDR_W'(d);
        p_valid = 1'b0; w_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("busy_set", busy, 1);
        check("done_single", done, 0);
        check("ovf_clear", ovf, 0);
        while (idx < n && cyc < 4000) begin
            check("p_ready_acc", p_ready, 1);
            check("wvalid_acc", w_valid, 0);
            v = ($urandom_range(99) >= gap_pct);
            p_valid = v;
            p_data = v ? P_W'(prods[idx]) : P_W'($urandom);
            start = ($urandom_range(7) == 0);
            len = CNT_W'($urandom); dest = ADDR_W'($urandom);
            w_ready = 1'($urandom);
            @(negedge clk);
            cyc++;
            if (v) idx++;
        end
        check("acc_count", idx, n);
        p_valid = 1'b0; start = 1'b0; w_ready = 1'b0;
        check("p_ready_drop", p_ready, 0);
        check("wvalid_set", w_valid, 1);
        check("w_addr", w_addr, d);
        check("w_data", w_data, exp_sum);
        check("ovf", ovf, exp_ovf);
        repeat (stall) begin
            start = 1'($urandom); len = CNT_W'($urandom); dest = ADDR_W'($urandom);
            @(negedge clk);
            check("stall_wvalid", w_valid, 1);
            check("stall_waddr", w_addr, d);
            check("stall_wdata", w_data, exp_sum);
            check("stall_done", done, 0);
            check("stall_pready", p_ready, 0);
        end
        start = 1'b0; w_ready = 1'b1;
        @(negedge clk);
        w_ready = 1'b0;
        check("done_pulse", done, 1);
        check("busy_clear", busy, 0);
        check("wvalid_clear", w_valid, 0);
        check("ovf_hold", ovf, exp_ovf);
    endtask

    initial begin
        int n;
        int r;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_pready", p_ready, 0);
        check("rst_wvalid", w_valid, 0);
        check("rst_waddr", w_addr, 0);
        check("rst_wdata", w_data, 0);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        idle(1);

        prods = '{2, 3, -1, 5};
        run_burst(4, 3, 0, 0);
        idle(2);
        prods = '{7, 7, 7};
        run_burst(3, 12, 70, 0);
        prods = '{-100, 250};
        run_burst(2, 31, 0, 5);
        prods.delete();
        run_burst(0, 7, 0, 0);
        prods.delete();
        repeat (65) prods.push_back(32767);
        run_burst(65, 1, 0, 1);
        prods.delete();
        repeat (65) prods.push_back(-32768);
        run_burst(65, 2, 10, 0);
        idle(1);

        start = 1'b1; len = 8'd4; dest = 5'd9;
        @(negedge clk);
        start = 1'b0; p_valid = 1'b1; p_data = 16'd10;
        @(negedge clk);
        p_data = 16'd20;
        @(negedge clk);
        p_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_pready", p_ready, 0);
        check("arst_wvalid", w_valid, 0);
        check("arst_waddr", w_addr, 0);
        check("arst_wdata", w_data, 0);
        check("arst_done", done, 0);
        check("arst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        prods = '{-4};
        run_burst(1, 5, 0, 0);

        for (int b = 0; b < 40; b++) begin
            n = ($urandom_range(9) == 0) ? $urandom_range(255, 60) : $urandom_range(12);
            prods.delete();
            for (int i = 0; i < n; i++) begin
                r = $urandom_range(3);
                prods.push_back(r == 0 ? 32767 : r == 1 ? -32768 : $urandom_range(65535) - 32768);
            end
            run_burst(n, $urandom_range(31), $urandom_range(60), $urandom_range(4));
            if ($urandom_range(1) == 1) idle($urandom_range(2, 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
